// File: rtl/hazard_stall_controller_if.sv
// Pipeline hazard bus: the datapath side (master) reports what sits in ID and
// EX, and the sequencing controller (slave) answers with enables, bubbles,
// flushes and its performance counters.
interface hazard_stall_controller_if #(
  parameter int unsigned CNT_W = 16
) ();

  // Hazard inputs to the controller
  logic             ID_EX_MemRead;
  logic [4:0]       ID_EX_RegisterRt;
  logic [4:0]       IF_ID_RegisterRs;
  logic [4:0]       IF_ID_RegisterRt;
  logic             ID_EX_MulDiv;
  logic             Branch_Taken;

  // Pipeline control outputs of the controller
  logic             PCWrite;
  logic             IF_ID_Write;
  logic             IF_ID_Flush;
  logic             ID_EX_Bubble;
  logic             ID_EX_Hold;
  logic             EX_MEM_Bubble;
  logic             muldiv_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
           ID_EX_MulDiv, Branch_Taken,
    input  PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Hold,
           EX_MEM_Bubble, muldiv_busy, stall_cycles, flush_count
  );

  modport slave (
    input  ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt,
           ID_EX_MulDiv, Branch_Taken,
    output PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Hold,
           EX_MEM_Bubble, muldiv_busy, stall_cycles, flush_count
  );

endinterface

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller for the 5-stage MIPS datapath. Decides, in the
// same cycle, whether to stall on a load-use hazard, flush on a taken branch
// resolved in EX, or freeze the front of the pipe while a multi-cycle mul/div
// occupies EX. Also keeps saturating stall and flush event counters.
module hazard_stall_controller #(
  parameter int unsigned MULDIV_LATENCY = 4,   // total EX cycles of a mul/div, 1..255
  parameter int unsigned CNT_W          = 16   // performance counter width
) (
  input  logic                    clk,
  input  logic                    rst,
  hazard_stall_controller_if.slave bus
);

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } state_t;

  // A single-cycle mul/div never needs the busy state.
  localparam bit             LONG_OP  = (MULDIV_LATENCY > 1);
  // Countdown load: the triggering RUN cycle is the first stall cycle, the
  // cnt==0 cycle in MD_BUSY is the release, so cnt starts at latency-2.
  localparam logic [7:0]     CNT_LOAD = LONG_OP ? 8'(MULDIV_LATENCY - 2) : 8'd0;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [7:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  state_t           w_state_nxt;
  logic [7:0]       w_cnt_nxt;
  logic             w_lu;
  logic             w_flush_evt;
  logic             w_pcwrite;
  logic             w_if_id_write;
  logic             w_if_id_flush;
  logic             w_id_ex_bubble;
  logic             w_id_ex_hold;
  logic             w_ex_mem_bubble;

  // Load-use detection; r0 is hardwired zero and never creates a dependency.
  assign w_lu = bus.ID_EX_MemRead
             && (bus.ID_EX_RegisterRt != 5'd0)
             && ((bus.ID_EX_RegisterRt == bus.IF_ID_RegisterRs)
              || (bus.ID_EX_RegisterRt == bus.IF_ID_RegisterRt));

  // Zero-latency control decision and FSM next-state from state, cnt and inputs.
  always_comb begin
    // NOTE: every signal written here gets its default first, so no path can infer a latch.
    w_pcwrite       = 1'b1;
    w_if_id_write   = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_bubble  = 1'b0;
    w_id_ex_hold    = 1'b0;
    w_ex_mem_bubble = 1'b0;
    w_flush_evt     = 1'b0;
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;

    // While reset is held the pipe free-runs with default controls.
    if (!rst) begin
      unique case (r_state)
        RUN: begin
          if (bus.Branch_Taken) begin
            // Squash the wrong-path instructions in IF/ID and ID/EX; PC takes the target.
            w_if_id_flush  = 1'b1;
            w_id_ex_bubble = 1'b1;
            w_flush_evt    = 1'b1;
          end else if (bus.ID_EX_MulDiv && LONG_OP) begin
            // First stall cycle of a multi-cycle op: freeze front, hold EX, bubble MEM.
            w_pcwrite       = 1'b0;
            w_if_id_write   = 1'b0;
            w_id_ex_hold    = 1'b1;
            w_ex_mem_bubble = 1'b1;
            w_state_nxt     = MD_BUSY;
            w_cnt_nxt       = CNT_LOAD;
          end else if (bus.ID_EX_MulDiv) begin
            // Single-cycle mul/div behaves like any ALU op: no stall.
            w_state_nxt = RUN;
          end else if (w_lu) begin
            // One bubble; it clears MemRead in EX next cycle, ending the hazard.
            w_pcwrite      = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
          end
        end

        MD_BUSY: begin
          if (r_cnt != 8'd0) begin
            w_pcwrite       = 1'b0;
            w_if_id_write   = 1'b0;
            w_id_ex_hold    = 1'b1;
            w_ex_mem_bubble = 1'b1;
            w_cnt_nxt       = r_cnt - 8'd1;
          end else begin
            // Release cycle: defaults let EX/MEM capture the result.
            w_state_nxt = RUN;
          end
        end

        default: w_state_nxt = RUN;
      endcase
    end
  end

  // FSM state and mul/div countdown registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state <= RUN;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Saturating performance counters for stall cycles and branch flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!w_pcwrite && (r_stall_cycles != CNT_MAX))
        r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_flush_evt && (r_flush_count != CNT_MAX))
        r_flush_count <= r_flush_count + 1'b1;
    end
  end

  assign bus.PCWrite       = w_pcwrite;
  assign bus.IF_ID_Write   = w_if_id_write;
  assign bus.IF_ID_Flush   = w_if_id_flush;
  assign bus.ID_EX_Bubble  = w_id_ex_bubble;
  assign bus.ID_EX_Hold    = w_id_ex_hold;
  assign bus.EX_MEM_Bubble = w_ex_mem_bubble;
  assign bus.muldiv_busy   = (r_state == MD_BUSY);
  assign bus.stall_cycles  = r_stall_cycles;
  assign bus.flush_count   = r_flush_count;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller. Four instances share one stimulus:
//   a: latency 4, 16-bit counters   b: latency 1
//   c: latency 3                    d: latency 4, 4-bit counters
// Control outputs are packed as {PCWrite, IF_ID_Write, IF_ID_Flush,
// ID_EX_Bubble, ID_EX_Hold, EX_MEM_Bubble, muldiv_busy}.
module tb_hazard_stall_controller;

  localparam logic [6:0] DEF     = 7'b1100000;
  localparam logic [6:0] LU      = 7'b0001000;
  localparam logic [6:0] FLUSH   = 7'b1111000;
  localparam logic [6:0] MD_RUN  = 7'b0000110;
  localparam logic [6:0] MD_BUSY = 7'b0000111;

  logic       clk;
  logic       rst;
  logic       memread;
  logic [4:0] ex_rt;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       muldiv;
  logic       branch;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_stall_controller_if #(.CNT_W(16)) if_a ();
  hazard_stall_controller_if #(.CNT_W(16)) if_b ();
  hazard_stall_controller_if #(.CNT_W(16)) if_c ();
  hazard_stall_controller_if #(.CNT_W(4))  if_d ();

  assign if_a.ID_EX_MemRead = memread;  assign if_b.ID_EX_MemRead = memread;
  assign if_c.ID_EX_MemRead = memread;  assign if_d.ID_EX_MemRead = memread;
  assign if_a.ID_EX_RegisterRt = ex_rt; assign if_b.ID_EX_RegisterRt = ex_rt;
  assign if_c.ID_EX_RegisterRt = ex_rt; assign if_d.ID_EX_RegisterRt = ex_rt;
  assign if_a.IF_ID_RegisterRs = id_rs; assign if_b.IF_ID_RegisterRs = id_rs;
  assign if_c.IF_ID_RegisterRs = id_rs; assign if_d.IF_ID_RegisterRs = id_rs;
  assign if_a.IF_ID_RegisterRt = id_rt; assign if_b.IF_ID_RegisterRt = id_rt;
  assign if_c.IF_ID_RegisterRt = id_rt; assign if_d.IF_ID_RegisterRt = id_rt;
  assign if_a.ID_EX_MulDiv = muldiv;    assign if_b.ID_EX_MulDiv = muldiv;
  assign if_c.ID_EX_MulDiv = muldiv;    assign if_d.ID_EX_MulDiv = muldiv;
  assign if_a.Branch_Taken = branch;    assign if_b.Branch_Taken = branch;
  assign if_c.Branch_Taken = branch;    assign if_d.Branch_Taken = branch;

  hazard_stall_controller #(.MULDIV_LATENCY(4), .CNT_W(16)) u_a (.clk(clk), .rst(rst), .bus(if_a));
  hazard_stall_controller #(.MULDIV_LATENCY(1), .CNT_W(16)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  hazard_stall_controller #(.MULDIV_LATENCY(3), .CNT_W(16)) u_c (.clk(clk), .rst(rst), .bus(if_c));
  hazard_stall_controller #(.MULDIV_LATENCY(4), .CNT_W(4))  u_d (.clk(clk), .rst(rst), .bus(if_d));

  logic [6:0] ctl_a, ctl_b, ctl_c;
  assign ctl_a = {if_a.PCWrite, if_a.IF_ID_Write, if_a.IF_ID_Flush, if_a.ID_EX_Bubble,
                  if_a.ID_EX_Hold, if_a.EX_MEM_Bubble, if_a.muldiv_busy};
  assign ctl_b = {if_b.PCWrite, if_b.IF_ID_Write, if_b.IF_ID_Flush, if_b.ID_EX_Bubble,
                  if_b.ID_EX_Hold, if_b.EX_MEM_Bubble, if_b.muldiv_busy};
  assign ctl_c = {if_c.PCWrite, if_c.IF_ID_Write, if_c.IF_ID_Flush, if_c.ID_EX_Bubble,
                  if_c.ID_EX_Hold, if_c.EX_MEM_Bubble, if_c.muldiv_busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    memread = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    muldiv = 1'b0; branch = 1'b0;
  endtask

  // Asynchronous reset pulse well away from the clock edges.
  task automatic pulse_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  logic [5:0] b2b_pat;

  initial begin
    // Reset with hazards present on the inputs: outputs must stay at defaults.
    rst = 1'b1;
    memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd0;
    muldiv = 1'b1; branch = 1'b1;
    #1;
    check("rst_ctl_a", ctl_a, DEF);
    check("rst_ctl_c", ctl_c, DEF);
    check("rst_stall_a", if_a.stall_cycles, 0);
    check("rst_flush_a", if_a.flush_count, 0);
    @(negedge clk);
    check("rst_edge_stall_a", if_a.stall_cycles, 0);
    check("rst_edge_busy_a", if_a.muldiv_busy, 0);
    rst = 1'b0;
    clear_inputs();
    #1 check("idle_ctl_a", ctl_a, DEF);

    // Load r5 in EX, rs=5 in ID: one bubble cycle.
    @(negedge clk);
    memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd7;
    #1 check("lu_rs_ctl_a", ctl_a, LU);
    @(negedge clk);
    memread = 1'b0;
    #1 check("lu_after_ctl_a", ctl_a, DEF);
    check("lu_stall_a", if_a.stall_cycles, 1);

    // Load r0 with rs=rt=0: no stall.
    memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1 check("lu_r0_ctl_a", ctl_a, DEF);

    // Match on rt only.
    @(negedge clk);
    ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9;
    #1 check("lu_rt_ctl_a", ctl_a, LU);
    check("lu_r0_stall_a", if_a.stall_cycles, 1);

    // Load destination matches neither source.
    @(negedge clk);
    id_rt = 5'd4;
    #1 check("lu_miss_ctl_a", ctl_a, DEF);
    check("lu_rt_stall_a", if_a.stall_cycles, 2);

    // Taken branch together with a load-use hazard: flush wins.
    @(negedge clk);
    id_rt = 5'd9; branch = 1'b1;
    #1 check("br_lu_ctl_a", ctl_a, FLUSH);
    @(negedge clk);
    clear_inputs();
    #1 check("br_after_ctl_a", ctl_a, DEF);
    check("br_flush_a", if_a.flush_count, 1);
    check("br_stall_a", if_a.stall_cycles, 2);

    // Mul/div, latency 4 on a (3 stalls, release), latency 1 on b (none).
    @(negedge clk);
    muldiv = 1'b1;
    #1 check("md1_ctl_a", ctl_a, MD_RUN);
    check("md1_ctl_b", ctl_b, DEF);
    @(negedge clk);
    #1 check("md2_ctl_a", ctl_a, MD_BUSY);
    @(negedge clk);
    #1 check("md3_ctl_a", ctl_a, MD_BUSY);
    @(negedge clk);
    #1 check("md4_release_a", ctl_a[6:1], 6'b110000);
    check("md4_ctl_b", ctl_b, DEF);
    @(negedge clk);
    muldiv = 1'b0;
    #1 check("md5_ctl_a", ctl_a, DEF);
    check("md_stall_a", if_a.stall_cycles, 5);
    check("md_stall_b", if_b.stall_cycles, 2);
    check("md_flush_b", if_b.flush_count, 1);

    // Back-to-back mul/div on c (latency 3): PCWrite 0,0,1,0,0,1.
    pulse_reset();
    b2b_pat = 6'b100100;
    @(negedge clk);
    muldiv = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1 check($sformatf("b2b_pcw_c_%0d", i), if_c.PCWrite, b2b_pat[i]);
      @(negedge clk);
    end
    muldiv = 1'b0;
    #1 check("b2b_stall_c", if_c.stall_cycles, 4);
    check("b2b_ctl_c", ctl_c, DEF);

    // Reset in MD_BUSY with cnt=1 on a, then a fresh mul/div restarts fully.
    pulse_reset();
    @(negedge clk);
    muldiv = 1'b1;
    #1 check("mdr1_ctl_a", ctl_a, MD_RUN);
    @(negedge clk);
    #1 check("mdr2_ctl_a", ctl_a, MD_BUSY);
    @(negedge clk);
    check("mdr_pre_stall_a", if_a.stall_cycles, 2);
    rst = 1'b1;
    #1 check("mdr_rst_ctl_a", ctl_a, DEF);
    check("mdr_rst_stall_a", if_a.stall_cycles, 0);
    check("mdr_rst_flush_a", if_a.flush_count, 0);
    @(negedge clk);
    check("mdr_rst_hold_ctl_a", ctl_a, DEF);
    rst = 1'b0;
    #1 check("mdr_new1_ctl_a", ctl_a, MD_RUN);
    @(negedge clk);
    #1 check("mdr_new2_ctl_a", ctl_a, MD_BUSY);
    @(negedge clk);
    #1 check("mdr_new3_ctl_a", ctl_a, MD_BUSY);
    @(negedge clk);
    #1 check("mdr_new4_release_a", ctl_a[6:1], 6'b110000);
    @(negedge clk);
    muldiv = 1'b0;
    #1 check("mdr_stall_a", if_a.stall_cycles, 3);
    check("mdr_end_ctl_a", ctl_a, DEF);

    // Saturation of the 4-bit stall counter on d under a held load-use hazard.
    pulse_reset();
    @(negedge clk);
    memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd0;
    repeat (15) @(negedge clk);
    #1 check("sat15_stall_d", if_d.stall_cycles, 15);
    repeat (5) @(negedge clk);
    #1 check("sat20_stall_d", if_d.stall_cycles, 15);
    check("sat20_stall_a", if_a.stall_cycles, 20);
    clear_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
